// File: rtl/regblock_ctrl_pkg.sv
// Shared definitions for the register-block instruction sequencer.
// Holds the controller state encoding, the opcode class constants, the
// special system opcodes and the bit positions of every instruction field.
// No ports: imported by regblock_ctrl and its wait timer.
package regblock_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALTED,
      S_ERROR
   } state_t;

   localparam logic [1:0] CLS_RALU = 2'b00;
   localparam logic [1:0] CLS_IALU = 2'b01;
   localparam logic [1:0] CLS_MEM  = 2'b10;
   localparam logic [1:0] CLS_SYS  = 2'b11;

   localparam logic [4:0] OP_NOP  = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11111;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RD_MSB  = 26;
   localparam int RD_LSB  = 21;
   localparam int RS_MSB  = 20;
   localparam int RS_LSB  = 15;
   localparam int RT_MSB  = 14;
   localparam int RT_LSB  = 9;
   localparam int IMM_MSB = 14;
   localparam int IMM_LSB = 0;

   // Within the 5-bit opcode, bit 0 distinguishes STORE from LOAD.
   localparam int OPC_STORE_BIT = 0;

   // The two top opcode bits select the instruction class.
   function automatic logic [1:0] opcode_class(input logic [4:0] opcode);
      return opcode[4:3];
   endfunction

endpackage

// File: rtl/regblock_ctrl_wait_timer.sv
// Wait-cycle timer used while the sequencer waits on the ALU or memory.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clear     - zero the count (asserted on every state change)
//   en        - a waiting cycle is in progress
//   expired   - this waiting cycle is the one that brings the count to TIMEOUT
module ctrl_wait_timer
   import regblock_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
)
(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;

   // Count waiting cycles since the last state entry; saturate at TIMEOUT
   // so a long stall can never wrap back to a small value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (en && (count_q != CW'(TIMEOUT))) begin
         count_q <= count_q + 1'b1;
      end
   end

   // Flag the cycle whose increment reaches TIMEOUT so the controller can
   // leave on that edge; a completion seen in the same cycle takes priority
   // in the controller.
   assign expired = en && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/regblock_ctrl.sv
// Instruction sequencer for the RegBlock/ALU/memory datapath.
// Accepts one instruction over instr_valid/instr_ready, decodes it onto the
// register block controls (rs, rt, rd, imm_in, mux_sel, alu_op), runs the
// ALU, optionally a memory access, and performs the single register write.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   instr_valid/instr/instr_ready  - instruction handshake
//   rs/rt/rd/wd/we/mux_sel/imm_in  - register block controls
//   alu_start/alu_op/alu_done/alu_result - ALU handshake
//   mem_req/mem_we/mem_ready/mem_rdata   - memory handshake
//   busy/halted/error              - status
module regblock_ctrl
   import regblock_ctrl_pkg::*;
#(
   parameter int RWIDTH  = 6,
   parameter int DWIDTH  = 32,
   parameter int IMM_IN  = 15,
   parameter int TIMEOUT = 64
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [31:0]       instr,
   output logic              instr_ready,
   output logic [RWIDTH-1:0] rs,
   output logic [RWIDTH-1:0] rt,
   output logic [RWIDTH-1:0] rd,
   output logic [DWIDTH-1:0] wd,
   output logic              we,
   output logic              mux_sel,
   output logic [IMM_IN-1:0] imm_in,
   output logic              alu_start,
   output logic [2:0]        alu_op,
   input  logic              alu_done,
   input  logic [DWIDTH-1:0] alu_result,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ready,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic              busy,
   output logic              halted,
   output logic              error
);

   state_t            state_q;
   state_t            state_d;
   logic [31:0]       instr_q;
   logic [DWIDTH-1:0] wd_q;
   logic              alu_start_q;
   logic [4:0]        opcode;
   logic [1:0]        op_class;
   logic              is_store;
   logic              timer_clear;
   logic              timer_en;
   logic              timer_expired;

   assign opcode   = instr_q[OPC_MSB:OPC_LSB];
   assign op_class = opcode_class(opcode);
   assign is_store = opcode[OPC_STORE_BIT];

   // State register; reset drops any in-flight instruction back to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sequencing. alu_done is ignored while alu_start is still high so the
   // ALU always gets at least one cycle, and a completion beats the timeout
   // when both land in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op_class == CLS_SYS) begin
               if (opcode == OP_NOP) begin
                  state_d = S_IDLE;
               end else if (opcode == OP_HALT) begin
                  state_d = S_HALTED;
               end else begin
                  state_d = S_ERROR;
               end
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!alu_start_q && alu_done) begin
               state_d = (op_class == CLS_MEM) ? S_MEM : S_WB;
            end else if (timer_expired) begin
               state_d = S_ERROR;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = is_store ? S_IDLE : S_WB;
            end else if (timer_expired) begin
               state_d = S_ERROR;
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath registers: the captured instruction (which drives all decode
   // outputs until the next accept), the write-back value, and the one-cycle
   // ALU start pulse issued on the edge into EXEC. wd only changes on the
   // edge into WB so it stays put whenever we is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q     <= '0;
         wd_q        <= '0;
         alu_start_q <= 1'b0;
      end else begin
         alu_start_q <= (state_q == S_DECODE) && (state_d == S_EXEC);
         if ((state_q == S_IDLE) && instr_valid) begin
            instr_q <= instr;
         end
         if ((state_q == S_EXEC) && (state_d == S_WB)) begin
            wd_q <= alu_result;
         end
         if ((state_q == S_MEM) && (state_d == S_WB)) begin
            wd_q <= mem_rdata;
         end
      end
   end

   // The timer restarts on every state change and only counts while the
   // controller is waiting on the ALU or memory.
   assign timer_clear = (state_d != state_q);
   assign timer_en    = (state_q == S_EXEC) || (state_q == S_MEM);

   ctrl_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .en      (timer_en),
      .expired (timer_expired)
   );

   // Decode outputs. A STORE reads its data register through port B, so rt
   // is taken from the rd field in that case.
   assign rs      = RWIDTH'(instr_q[RS_MSB:RS_LSB]);
   assign rd      = RWIDTH'(instr_q[RD_MSB:RD_LSB]);
   assign rt      = ((op_class == CLS_MEM) && is_store) ? RWIDTH'(instr_q[RD_MSB:RD_LSB])
                                                        : RWIDTH'(instr_q[RT_MSB:RT_LSB]);
   assign imm_in  = IMM_IN'(instr_q[IMM_MSB:IMM_LSB]);
   assign alu_op  = opcode[2:0];
   assign mux_sel = (op_class == CLS_IALU) || (op_class == CLS_MEM);

   // Handshake and status outputs follow the state directly, so an
   // asynchronous reset is visible on them without a clock edge.
   assign instr_ready = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign halted      = (state_q == S_HALTED);
   assign error       = (state_q == S_ERROR);
   assign we          = (state_q == S_WB);
   assign wd          = wd_q;
   assign alu_start   = alu_start_q;
   assign mem_req     = (state_q == S_MEM);
   assign mem_we      = (state_q == S_MEM) && is_store;

endmodule

// File: tb/tb_regblock_ctrl.sv
// Self-checking bench for regblock_ctrl. A driver issues instructions and
// plays the ALU and memory; expected decode, memory and write-back events
// are computed from the instruction fields and queued, and a monitor pops
// and compares them whenever the DUT presents the matching output.
module tb_regblock_ctrl;

   localparam int TIMEOUT = 64;

   localparam int SIG_READY  = 0;
   localparam int SIG_START  = 1;
   localparam int SIG_MEMREQ = 2;
   localparam int SIG_ERROR  = 3;
   localparam int SIG_HALTED = 4;

   typedef struct {
      logic [5:0]  rs;
      logic [5:0]  rt;
      logic [14:0] imm;
      logic [2:0]  alu_op;
      logic        mux_sel;
   } dec_t;

   typedef struct {
      logic [5:0]  rd;
      logic [31:0] wd;
      int          lat;
   } wb_t;

   typedef struct {
      logic       st;
      logic [5:0] rt;
      int         dur;
   } mem_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [5:0]  rs;
   logic [5:0]  rt;
   logic [5:0]  rd;
   logic [31:0] wd;
   logic        we;
   logic        mux_sel;
   logic [14:0] imm_in;
   logic        alu_start;
   logic [2:0]  alu_op;
   logic        alu_done;
   logic [31:0] alu_result;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        halted;
   logic        error;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int accept_cyc = 0;

   dec_t exp_dec[$];
   wb_t  exp_wb[$];
   mem_t exp_mem[$];

   regblock_ctrl #(
      .RWIDTH  (6),
      .DWIDTH  (32),
      .IMM_IN  (15),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .wd          (wd),
      .we          (we),
      .mux_sel     (mux_sel),
      .imm_in      (imm_in),
      .alu_start   (alu_start),
      .alu_op      (alu_op),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .halted      (halted),
      .error       (error)
   );

   // Free-running clock and a cycle counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case the driver ever gets lost.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                  name, actual, expected, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sigVal(input int which);
      case (which)
         SIG_READY:  return instr_ready;
         SIG_START:  return alu_start;
         SIG_MEMREQ: return mem_req;
         SIG_ERROR:  return error;
         default:    return halted;
      endcase
   endfunction

   // Wait (bounded) for a DUT output to go high; an expired bound shows up
   // as a failed comparison on that output.
   task automatic waitSig(input int which, input int bound, input string name);
      for (int n = 0; n < bound && !sigVal(which); n++) tick();
      checkOutput(name, 64'(sigVal(which)), 64'd1);
   endtask

   function automatic logic [31:0] makeInstr(input int op, input int rdf,
                                             input int rsf, input int low15);
      return 32'(op * (2 ** 27) + rdf * (2 ** 21) + rsf * (2 ** 15) + low15);
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_flags"},
                  {55'd0, instr_ready, busy, halted, error, we, mem_req, mem_we,
                   alu_start, mux_sel},
                  64'b1_0000_0000);
      checkOutput({tag, "_fields"}, {9'd0, rs, rt, rd, imm_in, alu_op, wd}, 64'd0);
   endtask

   // Issue one non-terminal instruction, queue what it should produce, then
   // act as ALU and memory with the given latencies and data.
   task automatic applyStimulus(input logic [31:0] w, input int alat, input int mlat,
                                input logic [31:0] ares, input logic [31:0] mdata);
      int   op;
      int   cls;
      bit   st;
      dec_t d;
      wb_t  b;
      mem_t m;
      op  = int'(w / (2 ** 27));
      cls = op / 8;
      st  = (op % 2) == 1;
      d.rs      = 6'((w / (2 ** 15)) % 64);
      d.imm     = 15'(w % (2 ** 15));
      d.alu_op  = 3'(op % 8);
      d.mux_sel = (cls == 1) || (cls == 2);
      b.rd      = 6'((w / (2 ** 21)) % 64);
      d.rt      = (cls == 2 && st) ? b.rd : 6'((w / (2 ** 9)) % 64);
      if (cls != 3) exp_dec.push_back(d);
      if (cls == 0 || cls == 1) begin
         b.wd  = ares;
         b.lat = 3 + alat;
         exp_wb.push_back(b);
      end
      if (cls == 2) begin
         m.st  = st;
         m.rt  = d.rt;
         m.dur = mlat;
         exp_mem.push_back(m);
         if (!st) begin
            b.wd  = mdata;
            b.lat = 3 + alat + mlat;
            exp_wb.push_back(b);
         end
      end

      waitSig(SIG_READY, 20, "ready_before_issue");
      instr       = w;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      instr       = $urandom();
      if (cls != 3) begin
         waitSig(SIG_START, 4, "alu_start_seen");
         repeat (alat) tick();
         alu_done   = 1'b1;
         alu_result = ares;
         tick();
         alu_done   = 1'b0;
         alu_result = $urandom();
         if (cls == 2) begin
            waitSig(SIG_MEMREQ, 4, "mem_req_seen");
            repeat (mlat - 1) tick();
            mem_ready = 1'b1;
            mem_rdata = mdata;
            tick();
            mem_ready = 1'b0;
            mem_rdata = $urandom();
         end
      end
   endtask

   task automatic resetPulse();
      rst = 1'b1;
      #1;
      checkResetOutputs("async_reset");
      exp_dec.delete();
      exp_wb.delete();
      exp_mem.delete();
      @(negedge clk);
      #2;
      rst = 1'b0;
      tick();
      checkOutput("ready_after_reset", 64'(instr_ready), 64'd1);
   endtask

   // Monitor: compare every decode, memory request and write-back the DUT
   // presents against the next queued expectation.
   initial begin : monitor
      dec_t d;
      wb_t  b;
      mem_t m;
      bit   mem_active;
      int   mem_cnt;
      int   mem_dur;
      mem_active = 0;
      mem_cnt    = 0;
      mem_dur    = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_active = 0;
         end else begin
            if (instr_valid && instr_ready) accept_cyc = cyc;
            if (alu_start) begin
               if (exp_dec.size() == 0) begin
                  checkOutput("unexpected_alu_start", 64'(alu_start), 64'd0);
               end else begin
                  d = exp_dec.pop_front();
                  checkOutput("rs", 64'(rs), 64'(d.rs));
                  checkOutput("rt", 64'(rt), 64'(d.rt));
                  checkOutput("imm_in", 64'(imm_in), 64'(d.imm));
                  checkOutput("alu_op", 64'(alu_op), 64'(d.alu_op));
                  checkOutput("mux_sel", 64'(mux_sel), 64'(d.mux_sel));
               end
            end
            if (mem_req && !mem_active) begin
               if (exp_mem.size() == 0) begin
                  checkOutput("unexpected_mem_req", 64'(mem_req), 64'd0);
               end else begin
                  m = exp_mem.pop_front();
                  checkOutput("mem_we", 64'(mem_we), 64'(m.st));
                  checkOutput("mem_rt", 64'(rt), 64'(m.rt));
                  mem_dur = m.dur;
               end
               mem_active = 1;
               mem_cnt    = 0;
            end
            if (mem_req) mem_cnt++;
            if (!mem_req && mem_active) begin
               checkOutput("mem_req_cycles", 64'(mem_cnt), 64'(mem_dur));
               mem_active = 0;
            end
            if (we) begin
               if (exp_wb.size() == 0) begin
                  checkOutput("unexpected_we", 64'(we), 64'd0);
               end else begin
                  b = exp_wb.pop_front();
                  checkOutput("wb_rd", 64'(rd), 64'(b.rd));
                  checkOutput("wb_wd", 64'(wd), 64'(b.wd));
                  checkOutput("wb_latency", 64'(cyc - accept_cyc), 64'(b.lat));
               end
            end
         end
      end
   end

   initial begin : driver
      int c0;
      bit any_ready;
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      alu_done    = 1'b0;
      alu_result  = '0;
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      #1;
      checkResetOutputs("initial_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();

      $display("[TB] directed instructions");
      applyStimulus(makeInstr(5'b00010, 12, 11, 63 * 512), 1, 1, 32'hAAAA_AAAA, 32'h0);
      waitSig(SIG_READY, 4, "ready_after_rtype");
      applyStimulus(makeInstr(5'b01001, 63, 0, 15'h1FFF), 2, 1, 32'hFFAA_FFAA, 32'h0);
      applyStimulus(makeInstr(5'b10000, 5, 7, 15'h0123), 1, 3, 32'h0000_1000, 32'h1234_5678);
      applyStimulus(makeInstr(5'b10001, 9, 3, 15'h7E00), 2, 2, 32'h0000_2000, 32'h0);
      applyStimulus(makeInstr(5'b00111, 0, 63, 15'h0000), 4, 1, 32'h0000_0001, 32'h0);
      applyStimulus(makeInstr(5'b11000, 17, 2, 15'h1234), 1, 1, 32'h0, 32'h0);

      $display("[TB] randomized instructions");
      for (int i = 0; i < 40; i++) begin
         int kind;
         int op;
         kind = $urandom_range(0, 4);
         case (kind)
            0:       op = $urandom_range(0, 7);
            1:       op = 8 + $urandom_range(0, 7);
            2:       op = 16 + 2 * $urandom_range(0, 3);
            3:       op = 17 + 2 * $urandom_range(0, 3);
            default: op = 24;
         endcase
         applyStimulus(makeInstr(op, $urandom_range(0, 63), $urandom_range(0, 63),
                                 $urandom_range(0, 32767)),
                       $urandom_range(1, 4), $urandom_range(1, 4), $urandom(), $urandom());
      end
      waitSig(SIG_READY, 20, "ready_after_random");

      $display("[TB] ALU timeout");
      exp_dec.push_back('{rs: 6'd4, rt: 6'd8, imm: 15'(8 * 512), alu_op: 3'd1, mux_sel: 1'b0});
      instr       = makeInstr(5'b00001, 3, 4, 8 * 512);
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      waitSig(SIG_START, 4, "timeout_alu_start");
      c0        = cyc;
      any_ready = 0;
      for (int n = 0; n < TIMEOUT + 8 && !error; n++) begin
         tick();
         if (instr_ready) any_ready = 1;
      end
      checkOutput("timeout_error", 64'(error), 64'd1);
      checkOutput("timeout_cycles", 64'(cyc - c0), 64'(TIMEOUT));
      checkOutput("timeout_ready_held_low", 64'(any_ready), 64'd0);
      repeat (3) tick();
      checkOutput("error_sticky", {62'd0, error, instr_ready}, 64'b10);
      resetPulse();

      $display("[TB] HALT");
      instr       = makeInstr(5'b11111, 0, 0, 0);
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      waitSig(SIG_HALTED, 4, "halted_seen");
      repeat (5) tick();
      checkOutput("halted_sticky", {61'd0, halted, error, instr_ready}, 64'b100);
      resetPulse();

      $display("[TB] illegal opcode");
      instr       = makeInstr(5'b11010, 1, 2, 3);
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      waitSig(SIG_ERROR, 4, "illegal_error_seen");
      checkOutput("illegal_not_halted", {62'd0, halted, instr_ready}, 64'd0);
      resetPulse();

      $display("[TB] reset during memory access");
      exp_dec.push_back('{rs: 6'd6, rt: 6'd0, imm: 15'd0, alu_op: 3'd0, mux_sel: 1'b1});
      exp_mem.push_back('{st: 1'b0, rt: 6'd0, dur: 0});
      instr       = makeInstr(5'b10000, 21, 6, 0);
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      waitSig(SIG_START, 4, "midop_alu_start");
      tick();
      alu_done   = 1'b1;
      alu_result = 32'h40;
      tick();
      alu_done = 1'b0;
      waitSig(SIG_MEMREQ, 4, "midop_mem_req");
      tick();
      #2;
      resetPulse();
      repeat (3) tick();
      checkOutput("no_we_after_midop_reset", {62'd0, we, busy}, 64'd0);

      checkOutput("exp_dec_drained", 64'(exp_dec.size()), 64'd0);
      checkOutput("exp_wb_drained", 64'(exp_wb.size()), 64'd0);
      checkOutput("exp_mem_drained", 64'(exp_mem.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
